// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester and the iterative GCD core.
//   GCD_WIDTH       : operand/result width common to requester and core
//   gcd_req_state_t : requester FSM states
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } gcd_req_state_t;

endpackage

// File: rtl/gcd_req_watchdog.sv
// Down-counter that bounds how long the requester waits for the core.
// Only instantiated when GCD_TIMEOUT_EN is defined.
// Ports:
//   clk     : clock, posedge
//   rst     : synchronous active-low reset
//   load    : reload the counter with TIMEOUT-1 (asserted on entry to RUN)
//   en      : count enable (requester is in RUN)
//   expired : en is high and TIMEOUT enabled cycles have elapsed since load
module gcd_req_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntInit;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/gcd_requester.sv
// Initiator for the iterative GCD core. Takes operand pairs from an upstream
// valid/ready stream, loads them into the core (core_rst low for LOAD_CYC
// cycles), lets the core run until core_rdy, then presents the result on a
// downstream valid/ready stream. One operation in flight at a time.
// Optional feature: define GCD_TIMEOUT_EN to abort a RUN after TIMEOUT cycles
// (result 0 with out_err=1). Without it RUN waits forever and out_err is 0.
// Ports:
//   clk, rst              : clock (posedge), synchronous active-low reset
//   in_valid/in_ready     : upstream handshake; in_x/in_y operands
//   core_xi/core_yi       : operands to core, held stable through LOAD and RUN
//   core_rst              : to core, 0 = load, 1 = compute (1 only in RUN)
//   core_xo/core_rdy      : core result and result-valid
//   out_valid/out_ready   : downstream handshake; out_gcd result, out_err abort flag
//   done_cnt              : results handed off downstream, wraps
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH    = GCD_WIDTH,
  parameter int unsigned LOAD_CYC = 2,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] core_xi,
  output logic [WIDTH-1:0] core_yi,
  output logic             core_rst,
  input  logic [WIDTH-1:0] core_xo,
  input  logic             core_rdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [15:0]      done_cnt
);

  localparam int unsigned LoadW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [LoadW-1:0] LoadInit = LoadW'(LOAD_CYC - 1);

  gcd_req_state_t   state_q, state_d;
  logic [LoadW-1:0] load_cnt_q, load_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             core_rst_q, core_rst_d;
  logic [WIDTH-1:0] xi_q, xi_d;
  logic [WIDTH-1:0] yi_q, yi_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
  logic             out_err_q, out_err_d;
  logic [15:0]      done_cnt_q, done_cnt_d;
  logic             wd_expired;

`ifdef GCD_TIMEOUT_EN
  logic wd_load;
  // Reload exactly on the LOAD->RUN transition so the count covers RUN cycles only.
  assign wd_load = (state_q == LOAD) && (load_cnt_q == '0);

  gcd_req_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .load    (wd_load),
    .en      (state_q == RUN),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    in_ready_d  = in_ready_q;
    core_rst_d  = core_rst_q;
    xi_d        = xi_q;
    yi_d        = yi_q;
    out_valid_d = out_valid_q;
    out_gcd_d   = out_gcd_q;
    out_err_d   = out_err_q;
    done_cnt_d  = done_cnt_q;

    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        core_rst_d = 1'b0;
        if (in_valid && in_ready_q) begin
          xi_d       = in_x;
          yi_d       = in_y;
          load_cnt_d = LoadInit;
          in_ready_d = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (load_cnt_q == '0) begin
          core_rst_d = 1'b1;
          state_d    = RUN;
        end else begin
          load_cnt_d = load_cnt_q - 1'b1;
        end
      end
      RUN: begin
        // A result arriving on the timeout cycle takes priority over the abort.
        if (core_rdy) begin
          out_gcd_d   = core_xo;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          core_rst_d  = 1'b0;
          state_d     = RESP;
        end else if (wd_expired) begin
          out_gcd_d   = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          core_rst_d  = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 16'd1;
          // Raise in_ready with the return to IDLE so the next pair can go immediately.
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      core_rst_q  <= 1'b0;
      xi_q        <= '0;
      yi_q        <= '0;
      out_valid_q <= 1'b0;
      out_gcd_q   <= '0;
      out_err_q   <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      in_ready_q  <= in_ready_d;
      core_rst_q  <= core_rst_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      out_valid_q <= out_valid_d;
      out_gcd_q   <= out_gcd_d;
      out_err_q   <= out_err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign core_rst  = core_rst_q;
  assign core_xi   = xi_q;
  assign core_yi   = yi_q;
  assign out_valid = out_valid_q;
  assign out_gcd   = out_gcd_q;
  assign out_err   = out_err_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester with a behavioural subtractive GCD core attached.
// Expected results come from Euclid's algorithm; a monitor pops them from a
// scoreboard queue on each downstream handshake.
`timescale 1ns/1ps
module tb_gcd_requester;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned LOAD_CYC = 2;
  localparam int unsigned TIMEOUT  = 8;
`ifdef GCD_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid, in_ready, core_rst, core_rdy, out_valid, out_ready, out_err;
  logic [WIDTH-1:0] in_x, in_y, core_xi, core_yi, core_xo, out_gcd;
  logic [15:0]      done_cnt;

  always #5 clk = ~clk;

  gcd_requester #(
    .WIDTH    (WIDTH),
    .LOAD_CYC (LOAD_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .core_xi   (core_xi),
    .core_yi   (core_yi),
    .core_rst  (core_rst),
    .core_xo   (core_xo),
    .core_rdy  (core_rdy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_err   (out_err),
    .done_cnt  (done_cnt)
  );

  // Subtractive GCD core: loads while rst=0, steps while rst=1. stub masks rdy.
  logic [WIDTH-1:0] cx = '0, cy = '0, cxo = '0;
  logic             crdy = 1'b0;
  logic             stub = 1'b0;
  always @(posedge clk) begin
    if (!core_rst) begin
      cx <= core_xi; cy <= core_yi; crdy <= 1'b0;
    end else if (!crdy) begin
      if (cx == 0 || cy == 0) begin cxo <= '0; crdy <= 1'b1; end
      else if (cx == cy)      begin cxo <= cx; crdy <= 1'b1; end
      else if (cx > cy)       cx <= cx - cy;
      else                    cy <= cy - cx;
    end
  end
  assign core_rdy = crdy & ~stub;
  assign core_xo  = cxo;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] sb_q[$];
  logic [15:0] exp_done = '0;
  bit          pend_done = 1'b0;
  bit          rand_bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {err, gcd}. Subtractive core needs sum(quotients)-1 steps; the result is seen
  // two RUN cycles after the last step, so it beats the watchdog iff steps+2 <= TIMEOUT.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    int unsigned a = x;
    int unsigned b = y;
    int unsigned t;
    int unsigned qsum = 0;
    if (x == 0 || y == 0) return 17'h0;
    while (b != 0) begin
      qsum += a / b;
      t = a % b; a = b; b = t;
    end
    if (TimeoutOn && (qsum - 1 + 2 > TIMEOUT)) return {1'b1, 16'h0};
    return {1'b0, a[15:0]};
  endfunction

  task automatic send(input logic [15:0] x, input logic [15:0] y, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_y = y;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sb_q.push_back(model(x, y));
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  0);
    check({tag, "_core_rst"},  32'(core_rst),  0);
    check({tag, "_core_xi"},   32'(core_xi),   0);
    check({tag, "_core_yi"},   32'(core_yi),   0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_gcd"},   32'(out_gcd),   0);
    check({tag, "_out_err"},   32'(out_err),   0);
    check({tag, "_done_cnt"},  32'(done_cnt),  0);
  endtask

  // Monitor: compares every downstream handshake against the scoreboard.
  initial begin
    logic [16:0] exp;
    forever begin
      @(negedge clk);
      if (pend_done) begin
        check("done_cnt", 32'(done_cnt), 32'(exp_done));
        pend_done = 1'b0;
      end
      if (rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got gcd %0d expected none", out_gcd);
        end else begin
          exp = sb_q.pop_front();
          check("out_gcd", 32'(out_gcd), 32'(exp[15:0]));
          check("out_err", 32'(out_err), 32'(exp[16]));
        end
        exp_done  = exp_done + 16'd1;
        pend_done = 1'b1;
      end
    end
  end

  // Random downstream backpressure, changed away from the monitor's sampling edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [16:0] e4;
    int k;
    int seen;
    in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    rst = 1'b1;

    // T1
    send(16'd48, 16'd18, 1'b1);
    drain(2000);
    check("t1_done_cnt", 32'(done_cnt), 1);

    // T2
    send(16'd0, 16'd5, 1'b1);
    send(16'd9, 16'd0, 1'b1);
    drain(2000);
    check("t2_done_cnt", 32'(done_cnt), 3);

    // T3: equal operands, minimum latency
    send(16'd7, 16'd7, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    check("t3_latency", 32'(k - 1), 32'(LOAD_CYC + 2));
    drain(2000);

    // T4: downstream stall holds the result
    @(posedge clk); #1 out_ready = 1'b0;
    e4 = model(16'd1071, 16'd462);
    send(16'd1071, 16'd462, 1'b1);
    k = 0;
    while (!out_valid && k < 5000) begin @(negedge clk); k++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_out_valid", 32'(out_valid), 1);
      check("t4_out_gcd",   32'(out_gcd),   32'(e4[15:0]));
      check("t4_in_ready",  32'(in_ready),  0);
      check("t4_done_held", 32'(done_cnt),  4);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain(2000);
    check("t4_done_cnt", 32'(done_cnt), 5);

    // Random operand pairs under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b1);
    end
    drain(20000);
    rand_bp = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    check("rand_done_cnt", 32'(done_cnt), 25);

    // T5: reset during RUN abandons the operation
    send(16'd65535, 16'd2, 1'b0);
    k = 0;
    while (!core_rst && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("t5");
    exp_done = '0;
    rst = 1'b1;
    send(16'd12, 16'd8, 1'b1);
    drain(2000);
    check("t5_done_cnt", 32'(done_cnt), 1);

    // T6: core never answers
    stub = 1'b1;
    send(16'd10, 16'd4, 1'b0);
`ifdef GCD_TIMEOUT_EN
    sb_q.push_back({1'b1, 16'h0});
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    check("t6_timeout_latency", 32'(k - 1), 32'(LOAD_CYC + TIMEOUT));
    drain(2000);
    check("t6_done_cnt", 32'(done_cnt), 2);
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("t6_no_valid", 32'(seen), 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif
    stub = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
